// File: rtl/lsu_pkg.sv
// Shared LSU constants, FSM state type and request legality check.
// Imported by the interface, the aligner and the top-level stage.
package lsu_pkg;

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_e;

    // Misaligned halfword/word access or an undefined width encoding.
    function automatic logic lsu_bad_req(
        input logic       is_ld,
        input logic [2:0] f3,
        input logic [1:0] a
    );
        logic w_bad_f3;
        logic w_misal;
        if (is_ld)
            w_bad_f3 = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
        else
            w_bad_f3 = (f3 >= 3'b011);
        w_misal = ((f3[1:0] == 2'b01) & a[0])
                | ((f3[1:0] == 2'b10) & (a != 2'b00));
        return w_bad_f3 | w_misal;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Single-port data-memory request/response bus.
// The LSU is the master; the memory is the slave.
interface lsu_mem_stage_if #(
    parameter int DM_ADDR_W = 32
);
    logic                 dm_req;
    logic [3:0]           dm_we;
    logic [DM_ADDR_W-1:0] dm_addr;
    logic [31:0]          dm_wdata;
    logic                 dm_ready;
    logic                 dm_rvalid;
    logic [31:0]          dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_ready, dm_rvalid, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_ready, dm_rvalid, dm_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Load lane extraction and sign/zero extension of the memory word.
// Purely combinational.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_a,
    input  logic [2:0]  i_func3,
    output logic [31:0] o_data
);

    logic [7:0]  w_b;
    logic [15:0] w_h;

    always_comb begin
        w_b = i_rdata[{i_a, 3'b000} +: 8];
        w_h = i_rdata[{i_a[1], 4'b0000} +: 16];
        o_data = i_rdata;
        unique case (i_func3)
            F3_B:    o_data = {{24{w_b[7]}}, w_b};
            F3_H:    o_data = {{16{w_h[15]}}, w_h};
            F3_W:    o_data = i_rdata;
            F3_BU:   o_data = {24'd0, w_b};
            F3_HU:   o_data = {16'd0, w_h};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store unit after EX: one outstanding data-memory access,
// store lane steering, load extraction, stall and fault pulses.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int DM_ADDR_W = 32,
    parameter int WAIT_MAX  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ex_valid,
    input  logic [4:0]  i_opcode,
    input  logic [2:0]  i_func3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    output logic        o_lsu_busy,
    lsu_mem_stage_if.master dm,
    output logic        o_wb_valid,
    output logic [31:0] o_wb_data,
    output logic        o_lsu_fault
);

    localparam logic [31:0] W_MAX = 32'(WAIT_MAX);

    lsu_state_e r_state;
    lsu_state_e w_state_nxt;

    logic                 r_ld;
    logic [2:0]           r_f3;
    logic [1:0]           r_a;
    logic [DM_ADDR_W-1:0] r_addr;
    logic [3:0]           r_we;
    logic [31:0]          r_wdata;
    logic [31:0]          r_wcnt;
    logic                 r_fault;
    logic                 r_wb_valid;
    logic [31:0]          r_wb_data;

    logic        w_is_ld;
    logic        w_is_st;
    logic        w_req;
    logic        w_bad;
    logic        w_accept;
    logic        w_capture;
    logic        w_timeout;
    logic [31:0] w_wcnt_nxt;
    logic [3:0]  w_we;
    logic [31:0] w_wdata;
    logic [31:0] w_ld_data;

    always_comb begin
        w_is_ld  = (i_opcode == OP_LOAD);
        w_is_st  = (i_opcode == OP_STORE);
        w_req    = (r_state == IDLE) & i_ex_valid & (w_is_ld | w_is_st);
        w_bad    = lsu_bad_req(w_is_ld, i_func3, i_addr[1:0]);
        w_accept = w_req & ~w_bad;
    end

    // Store lane steering; loads drive no strobes.
    always_comb begin
        w_we    = 4'b0000;
        w_wdata = 32'd0;
        if (w_is_st) begin
            unique case (1'b1)
                (i_func3 == F3_B): begin
                    w_we    = 4'b0001 << i_addr[1:0];
                    w_wdata = {4{i_store_data[7:0]}};
                end
                (i_func3 == F3_H): begin
                    w_we    = i_addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{i_store_data[15:0]}};
                end
                (i_func3 == F3_W): begin
                    w_we    = 4'b1111;
                    w_wdata = i_store_data;
                end
                default: begin
                    w_we    = 4'b0000;
                    w_wdata = 32'd0;
                end
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_wcnt_nxt  = 32'd0;
        unique case (r_state)
            IDLE: begin
                if (w_accept)
                    w_state_nxt = REQ;
            end
            REQ: begin
                if (dm.dm_ready) begin
                    if (!r_ld) begin
                        w_state_nxt = IDLE;
                    end else if (dm.dm_rvalid) begin
                        w_capture   = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dm.dm_rvalid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_wcnt_nxt = r_wcnt + 32'd1;
                    if ((WAIT_MAX != 0) && (w_wcnt_nxt == W_MAX)) begin
                        w_timeout   = 1'b1;
                        w_wcnt_nxt  = 32'd0;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    lsu_load_align u_align (
        .i_rdata (dm.dm_rdata),
        .i_a     (r_a),
        .i_func3 (r_f3),
        .o_data  (w_ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ld       <= 1'b0;
            r_f3       <= 3'd0;
            r_a        <= 2'd0;
            r_addr     <= '0;
            r_we       <= 4'd0;
            r_wdata    <= 32'd0;
            r_wcnt     <= 32'd0;
            r_fault    <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wcnt     <= w_wcnt_nxt;
            r_fault    <= (w_req & w_bad) | w_timeout;
            r_wb_valid <= w_capture;
            if (w_capture)
                r_wb_data <= w_ld_data;
            if (w_accept) begin
                r_ld    <= w_is_ld;
                r_f3    <= i_func3;
                r_a     <= i_addr[1:0];
                r_addr  <= {i_addr[DM_ADDR_W-1:2], 2'b00};
                r_we    <= w_we;
                r_wdata <= w_wdata;
            end
        end
    end

    // Bus fields are held in registers and only exposed while in REQ.
    always_comb begin
        dm.dm_req   = (r_state == REQ);
        dm.dm_we    = (r_state == REQ) ? r_we : 4'd0;
        dm.dm_addr  = (r_state == REQ) ? r_addr : '0;
        dm.dm_wdata = (r_state == REQ) ? r_wdata : 32'd0;
    end

    assign o_lsu_busy  = (r_state != IDLE) | w_accept;
    assign o_wb_valid  = r_wb_valid;
    assign o_wb_data   = r_wb_data;
    assign o_lsu_fault = r_fault;

endmodule
